// File: rtl/bcd_scan_display_if.sv
// Bundle between the operand sources and the scanned 7-segment display driver.
interface bcd_scan_display_if #(
  parameter int DIGITS = 4
);
  logic                  run;
  logic [1:0]            mode;
  logic                  blankLz;
  logic [4*DIGITS-1:0]   aBcd;
  logic [4*DIGITS-1:0]   bBcd;
  logic [DIGITS-1:0]     an;
  logic [7*DIGITS-1:0]   seg;
  logic                  neg;
  logic                  err;

  modport master (
    output run, mode, blankLz, aBcd, bBcd,
    input  an, seg, neg, err
  );

  modport slave (
    input  run, mode, blankLz, aBcd, bBcd,
    output an, seg, neg, err
  );
endinterface

// File: rtl/bcd_scan_display.sv
// Time-multiplexed BCD to 7-segment driver: shows A, B, the signed difference
// B-A computed digit-serially in BCD, or a lamp test, one frame at a time.
module bcd_scan_display #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 4096
) (
  input  logic              i_clock,
  input  logic              i_reset,
  bcd_scan_display_if.slave io_disp
);

  localparam int SW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int AW = 4 * DIGITS;
  localparam int GW = 7 * DIGITS;
  localparam logic [IW-1:0] MSD       = IW'(DIGITS - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(PRESCALE - 1);
  localparam logic [6:0]    SEG_DASH  = 7'b1111110;
  localparam logic [6:0]    SEG_BLANK = 7'b1111111;

  typedef enum logic { ENG_IDLE, ENG_RUN } engState_t;

  function automatic logic [6:0] segOf(input logic [3:0] code);
    case (code)
      4'd0:    segOf = 7'b0000001;
      4'd1:    segOf = 7'b1001111;
      4'd2:    segOf = 7'b0010010;
      4'd3:    segOf = 7'b0000110;
      4'd4:    segOf = 7'b1001100;
      4'd5:    segOf = 7'b0100100;
      4'd6:    segOf = 7'b0100000;
      4'd7:    segOf = 7'b0001111;
      4'd8:    segOf = 7'b0000000;
      4'd9:    segOf = 7'b0000100;
      default: segOf = SEG_DASH;
    endcase
  endfunction

  // scan state
  logic [SW-1:0]     r_slot;
  logic [IW-1:0]     r_index;
  logic [IW-1:0]     r_shownIdx;
  logic              r_scanning;
  logic [DIGITS-1:0] r_an;
  logic              w_boundary;

  // snapshot and difference engine
  logic [AW-1:0]     r_snapA;
  logic [AW-1:0]     r_snapB;
  logic [1:0]        r_snapMode;
  logic              r_snapBlank;
  logic              r_snapValid;
  engState_t         r_engState;
  logic [IW-1:0]     r_engIdx;
  logic              r_brBA;
  logic              r_brAB;
  logic [AW-1:0]     r_accBA;
  logic [AW-1:0]     r_accAB;
  logic [AW-1:0]     r_pendDigits;
  logic              r_pendNeg;

  logic [3:0]        w_digA;
  logic [3:0]        w_digB;
  logic [4:0]        w_subBA;
  logic [4:0]        w_subAB;
  logic [3:0]        w_digBA;
  logic [3:0]        w_digAB;
  logic              w_brBANext;
  logic              w_brABNext;
  logic [AW-1:0]     w_accBANext;
  logic [AW-1:0]     w_accABNext;

  // frame result and display state
  logic              w_aBad;
  logic              w_bBad;
  logic [AW-1:0]     w_codes;
  logic [3:0]        w_code;
  logic              w_seen;
  logic [GW-1:0]     w_resSeg;
  logic              w_resNeg;
  logic              w_resErr;
  logic [GW-1:0]     r_buf;
  logic [GW-1:0]     r_seg;
  logic              r_neg;
  logic              r_err;

  // A frame starts on the first slot of the most significant digit; right
  // after reset the counters already sit there, so that slot is a boundary too.
  assign w_boundary = (r_slot == '0) && (r_index == MSD);

  // Slot prescaler and MSD-first digit index; the strobe is registered from the index.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_slot     <= '0;
      r_index    <= MSD;
      r_shownIdx <= MSD;
      r_scanning <= 1'b0;
      r_an       <= '1;
    end else begin
      r_an       <= ~(DIGITS'(1) << r_index);
      r_shownIdx <= r_index;
      r_scanning <= 1'b1;
      if (r_slot == SLOT_LAST) begin
        r_slot  <= '0;
        r_index <= (r_index == '0) ? MSD : r_index - IW'(1);
      end else begin
        r_slot <= r_slot + SW'(1);
      end
    end
  end

  // One BCD digit of B-A and A-B per clock, LSD first, with ripple borrows.
  always_comb begin
    w_digA = '0;
    w_digB = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_engIdx == IW'(i)) begin
        w_digA = r_snapA[4*i +: 4];
        w_digB = r_snapB[4*i +: 4];
      end
    end
    w_subBA    = {1'b0, w_digB} - {1'b0, w_digA} - {4'b0000, r_brBA};
    w_subAB    = {1'b0, w_digA} - {1'b0, w_digB} - {4'b0000, r_brAB};
    w_brBANext = w_subBA[4];
    w_brABNext = w_subAB[4];
    w_digBA    = w_subBA[4] ? (w_subBA[3:0] + 4'd10) : w_subBA[3:0];
    w_digAB    = w_subAB[4] ? (w_subAB[3:0] + 4'd10) : w_subAB[3:0];
    w_accBANext = r_accBA;
    w_accABNext = r_accAB;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_engIdx == IW'(i)) begin
        w_accBANext[4*i +: 4] = w_digBA;
        w_accABNext[4*i +: 4] = w_digAB;
      end
    end
  end

  // Snapshot capture at a running boundary, which also launches the difference
  // engine; the engine parks its signed magnitude in the pending register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_snapA      <= '0;
      r_snapB      <= '0;
      r_snapMode   <= 2'b00;
      r_snapBlank  <= 1'b0;
      r_snapValid  <= 1'b0;
      r_engState   <= ENG_IDLE;
      r_engIdx     <= '0;
      r_brBA       <= 1'b0;
      r_brAB       <= 1'b0;
      r_accBA      <= '0;
      r_accAB      <= '0;
      r_pendDigits <= '0;
      r_pendNeg    <= 1'b0;
    end else if (w_boundary && io_disp.run) begin
      r_snapA     <= io_disp.aBcd;
      r_snapB     <= io_disp.bBcd;
      r_snapMode  <= io_disp.mode;
      r_snapBlank <= io_disp.blankLz;
      r_snapValid <= 1'b1;
      r_engState  <= ENG_RUN;
      r_engIdx    <= '0;
      r_brBA      <= 1'b0;
      r_brAB      <= 1'b0;
      r_accBA     <= '0;
      r_accAB     <= '0;
    end else if (r_engState == ENG_RUN) begin
      r_accBA <= w_accBANext;
      r_accAB <= w_accABNext;
      r_brBA  <= w_brBANext;
      r_brAB  <= w_brABNext;
      if (r_engIdx == MSD) begin
        r_engState   <= ENG_IDLE;
        r_pendDigits <= w_brBANext ? w_accABNext : w_accBANext;
        r_pendNeg    <= w_brBANext;
      end else begin
        r_engIdx <= r_engIdx + IW'(1);
      end
    end
  end

  // Turn the current snapshot (and pending difference) into segment patterns,
  // applying dash substitution, leading-zero blanking, sign and error flags.
  always_comb begin
    w_aBad = 1'b0;
    w_bBad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_snapA[4*i +: 4] > 4'd9) w_aBad = 1'b1;
      if (r_snapB[4*i +: 4] > 4'd9) w_bBad = 1'b1;
    end
    w_codes  = (r_snapMode == 2'b10) ? r_pendDigits : (r_snapMode[0] ? r_snapB : r_snapA);
    w_resSeg = {GW{1'b1}};
    w_resNeg = 1'b0;
    w_resErr = 1'b0;
    w_seen   = 1'b0;
    w_code   = '0;
    if (r_snapValid) begin
      if (r_snapMode == 2'b11) begin
        w_resSeg = '0;
      end else if ((r_snapMode == 2'b10) && (w_aBad || w_bBad)) begin
        for (int i = 0; i < DIGITS; i++) w_resSeg[7*i +: 7] = SEG_DASH;
        w_resErr = 1'b1;
      end else begin
        for (int i = DIGITS - 1; i >= 0; i--) begin
          w_code = w_codes[4*i +: 4];
          if (w_code != 4'd0) w_seen = 1'b1;
          if (w_code > 4'd9) w_resErr = 1'b1;
          if (r_snapBlank && !w_seen && (i != 0)) w_resSeg[7*i +: 7] = SEG_BLANK;
          else                                   w_resSeg[7*i +: 7] = segOf(w_code);
        end
        w_resNeg = (r_snapMode == 2'b10) && r_pendNeg;
      end
    end
  end

  // Display buffer plus sign/error flags change only at a running boundary;
  // the buffer holds ready-made patterns and starts out blank.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_buf <= {GW{1'b1}};
      r_neg <= 1'b0;
      r_err <= 1'b0;
    end else if (w_boundary && io_disp.run) begin
      r_buf <= w_resSeg;
      r_neg <= w_resNeg;
      r_err <= w_resErr;
    end
  end

  // Refresh the strobed digit's pattern one clock into its slot; frozen while held.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_seg <= {GW{1'b1}};
    end else if (r_scanning && io_disp.run) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (r_shownIdx == IW'(i)) r_seg[7*i +: 7] <= r_buf[7*i +: 7];
      end
    end
  end

  assign io_disp.an  = r_an;
  assign io_disp.seg = r_seg;
  assign io_disp.neg = r_neg;
  assign io_disp.err = r_err;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display: stimulus queues per-frame expectations,
// a monitor compares them at the end of each frame and checks the scan strobe.
module tb_bcd_scan_display;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 2;
  localparam int FRAME    = DIGITS * PRESCALE;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SD = 7'b1111110;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SL = 7'b0000000;

  typedef struct {
    string       name;
    int          frame;
    bit          isReset;
    logic [27:0] seg;
    logic        neg;
    logic        err;
  } expect_t;

  expect_t expQ[$];

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checkCount = 0;
  int   passCount = 0;

  bcd_scan_display_if #(.DIGITS(DIGITS)) dispIf ();

  bcd_scan_display #(
    .DIGITS(DIGITS),
    .PRESCALE(PRESCALE)
  ) dut (
    .i_clock(clock),
    .i_reset(reset),
    .io_disp(dispIf)
  );

  // free-running clock
  always #5 clock = ~clock;

  function automatic logic [27:0] digits4(input logic [6:0] d3, input logic [6:0] d2,
                                          input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic applyStimulus(input logic run, input logic [1:0] mode, input logic blankLz,
                               input logic [15:0] a, input logic [15:0] b);
    dispIf.run     = run;
    dispIf.mode    = mode;
    dispIf.blankLz = blankLz;
    dispIf.aBcd    = a;
    dispIf.bBcd    = b;
  endtask

  task automatic checkOutput(input string name, input int frame, input logic [27:0] seg,
                             input logic neg, input logic err);
    expect_t e;
    e.name = name; e.frame = frame; e.isReset = 1'b0;
    e.seg = seg; e.neg = neg; e.err = err;
    expQ.push_back(e);
  endtask

  task automatic expectReset(input string name);
    expect_t e;
    e.name = name; e.frame = -1; e.isReset = 1'b1;
    e.seg = {4{SB}}; e.neg = 1'b0; e.err = 1'b0;
    expQ.push_back(e);
  endtask

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] want);
    checkCount++;
    if (got === want) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
  endtask

  task automatic waitFrame(input int f);
    int guard = 0;
    while (cyc != f * FRAME + 2 && guard < 2000) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 2000) begin
      checkCount++;
      $display("[TB] FAIL waitFrame%0d: timed out at cycle %0d", f, cyc);
    end
  endtask

  // monitor: strobe model every clock, queued expectations at each frame end
  initial begin : monitor
    expect_t    e;
    int         f;
    int         idx;
    logic [3:0] wantAn;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        cyc = 0;
        compare("anReset", 32'(dispIf.an), 32'h0000000F);
        if (expQ.size() > 0 && expQ[0].isReset) begin
          e = expQ.pop_front();
          compare({e.name, ".seg"}, 32'(dispIf.seg), 32'(e.seg));
          compare({e.name, ".neg"}, 32'(dispIf.neg), 32'(e.neg));
          compare({e.name, ".err"}, 32'(dispIf.err), 32'(e.err));
        end
      end else begin
        cyc++;
        idx    = DIGITS - 1 - (((cyc - 1) / PRESCALE) % DIGITS);
        wantAn = ~(4'b0001 << idx);
        compare($sformatf("an@%0d", cyc), 32'(dispIf.an), 32'(wantAn));
        if (cyc % FRAME == 0) begin
          f = cyc / FRAME - 1;
          while (expQ.size() > 0 && !expQ[0].isReset && expQ[0].frame <= f) begin
            e = expQ.pop_front();
            if (e.frame < f) begin
              checkCount++;
              $display("[TB] FAIL %s: frame %0d passed unchecked, now frame %0d", e.name, e.frame, f);
            end else begin
              compare({e.name, ".seg"}, 32'(dispIf.seg), 32'(e.seg));
              compare({e.name, ".neg"}, 32'(dispIf.neg), 32'(e.neg));
              compare({e.name, ".err"}, 32'(dispIf.err), 32'(e.err));
            end
          end
        end
      end
    end
  end

  // directed stimulus with hand-computed expected frames
  initial begin : stimulus
    expect_t e;
    reset = 1'b1;
    applyStimulus(1'b1, 2'b00, 1'b0, 16'h1234, 16'h0000);
    expectReset("resetInit");
    repeat (3) @(negedge clock);
    checkOutput("frame0Blank", 0, {4{SB}}, 1'b0, 1'b0);
    checkOutput("showA1234", 1, digits4(S1, S2, S3, S4), 1'b0, 1'b0);
    reset = 1'b0;

    waitFrame(2);
    applyStimulus(1'b1, 2'b10, 1'b1, 16'h0150, 16'h0100);
    checkOutput("midFrameIgnored", 3, digits4(S1, S2, S3, S4), 1'b0, 1'b0);
    checkOutput("diffNeg50", 4, digits4(SB, SB, S5, S0), 1'b1, 1'b0);

    waitFrame(4);
    applyStimulus(1'b1, 2'b10, 1'b1, 16'h0100, 16'h0150);
    checkOutput("diffPos50", 6, digits4(SB, SB, S5, S0), 1'b0, 1'b0);

    waitFrame(6);
    applyStimulus(1'b1, 2'b00, 1'b0, 16'h12A4, 16'h0000);
    checkOutput("invalidA", 8, digits4(S1, S2, SD, S4), 1'b0, 1'b1);

    waitFrame(8);
    applyStimulus(1'b1, 2'b10, 1'b0, 16'h12A4, 16'h0100);
    checkOutput("invalidDiff", 10, {4{SD}}, 1'b0, 1'b1);

    waitFrame(10);
    applyStimulus(1'b1, 2'b10, 1'b0, 16'h9999, 16'h0000);
    checkOutput("fullScaleNeg", 12, digits4(S9, S9, S9, S9), 1'b1, 1'b0);

    waitFrame(12);
    applyStimulus(1'b1, 2'b10, 1'b0, 16'h0000, 16'h9999);
    checkOutput("fullScalePos", 14, digits4(S9, S9, S9, S9), 1'b0, 1'b0);

    waitFrame(14);
    applyStimulus(1'b1, 2'b10, 1'b1, 16'h4321, 16'h4321);
    checkOutput("zeroDiffBlank", 16, digits4(SB, SB, SB, S0), 1'b0, 1'b0);

    waitFrame(16);
    applyStimulus(1'b1, 2'b01, 1'b1, 16'h9999, 16'h0A05);
    checkOutput("showBDashLz", 18, digits4(SB, SD, S0, S5), 1'b0, 1'b1);

    waitFrame(18);
    applyStimulus(1'b1, 2'b00, 1'b0, 16'h1234, 16'h0000);
    checkOutput("preHold", 20, digits4(S1, S2, S3, S4), 1'b0, 1'b0);

    waitFrame(21);
    applyStimulus(1'b0, 2'b00, 1'b0, 16'h5678, 16'h0000);
    for (int k = 21; k <= 24; k++)
      checkOutput($sformatf("hold%0d", k), k, digits4(S1, S2, S3, S4), 1'b0, 1'b0);

    waitFrame(24);
    applyStimulus(1'b1, 2'b00, 1'b0, 16'h5678, 16'h0000);
    checkOutput("resumeOld", 25, digits4(S1, S2, S3, S4), 1'b0, 1'b0);
    checkOutput("resume5678", 26, digits4(S5, S6, S7, S8), 1'b0, 1'b0);

    waitFrame(26);
    applyStimulus(1'b1, 2'b11, 1'b1, 16'h0000, 16'h0000);
    checkOutput("lampTest", 28, {4{SL}}, 1'b0, 1'b0);

    waitFrame(28);
    applyStimulus(1'b1, 2'b10, 1'b0, 16'h0001, 16'h0000);

    waitFrame(29);
    expectReset("resetMidEngine");
    reset = 1'b1;
    @(negedge clock);
    checkOutput("frame0AfterReset", 0, {4{SB}}, 1'b0, 1'b0);
    checkOutput("diffAfterReset", 1, digits4(S0, S0, S0, S1), 1'b1, 1'b0);
    reset = 1'b0;

    waitFrame(2);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkCount++;
      $display("[TB] FAIL %s: expectation for frame %0d never reached", e.name, e.frame);
    end
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
